// File: rtl/fmap_window_buffer.sv
// fmap_window_buffer: raster pixels in, 3x3 zero-padded per-channel windows out at STRIDE, 1 cycle after the enabling beat.
// in_ready drops for EDGE/FLUSH stall cycles; no output backpressure. Define WINBUF_FRAME_DONE_EN to add frame_done.
module fmap_window_buffer #(
    parameter int bitsize  = 18,
    parameter int CH       = 16,
    parameter int IMG_SIZE = 112,
    parameter int STRIDE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH*bitsize-1:0]   in_pixel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CH*9*bitsize-1:0] out_window,
    output logic                    out_valid
`ifdef WINBUF_FRAME_DONE_EN
    ,
    output logic                    frame_done
`endif
);
    localparam int PW = CH * bitsize;
    localparam int WW = CH * 9 * bitsize;
    localparam int AW = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam logic [AW-1:0] LAST      = AW'(IMG_SIZE - 1);
    localparam logic [AW-1:0] LAST_EMIT = AW'(((IMG_SIZE - 1) / STRIDE) * STRIDE);

    typedef enum logic [1:0] {RUN, EDGE, FLUSH} state_t;
    // One window column, index 0 is the top row (ky=0).
    typedef logic [2:0][PW-1:0] col_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic [AW-1:0] fc_q, fc_d, edge_row_q, edge_row_d;
    logic          last_row_q, last_row_d;
    col_t          col_a_q, col_a_d, col_b_q, col_b_d;
    logic [WW-1:0] out_window_q, out_window_d;
    logic          out_valid_q, out_valid_d;

    logic [PW-1:0] lb_top_mem [IMG_SIZE];
    logic [PW-1:0] lb_mid_mem [IMG_SIZE];

    logic          accept;
    logic [AW-1:0] rd_addr, win_row, win_col;
    logic          win_due, pad_top, pad_bot, pad_left, pad_right, shift_en, tap_pad;
    col_t          rd_col;
    col_t          win_cols [3];

    assign accept = in_valid & in_ready;

    // Line buffers shift one row down per accepted beat; stale entries are masked by padding.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top_mem[wr_c_q] <= lb_mid_mem[wr_c_q];
            lb_mid_mem[wr_c_q] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wr_r_q       <= '0;
            wr_c_q       <= '0;
            fc_q         <= '0;
            edge_row_q   <= '0;
            last_row_q   <= 1'b0;
            col_a_q      <= '0;
            col_b_q      <= '0;
            out_window_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_r_q       <= wr_r_d;
            wr_c_q       <= wr_c_d;
            fc_q         <= fc_d;
            edge_row_q   <= edge_row_d;
            last_row_q   <= last_row_d;
            col_a_q      <= col_a_d;
            col_b_q      <= col_b_d;
            out_window_q <= out_window_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && wr_c_q == LAST && wr_r_q != '0) state_d = EDGE;
            EDGE:    state_d = last_row_q ? FLUSH : RUN;
            FLUSH:   if (fc_q == LAST) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Per-state choice of which window is due and which of its borders are padding.
    always_comb begin
        in_ready  = (state_q == RUN);
        rd_addr   = wr_c_q;
        win_due   = 1'b0;
        win_row   = wr_r_q - AW'(1);
        win_col   = wr_c_q - AW'(1);
        pad_top   = 1'b0;
        pad_bot   = 1'b0;
        pad_left  = 1'b0;
        pad_right = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            RUN: begin
                win_due  = accept && wr_r_q != '0 && wr_c_q != '0;
                pad_top  = (wr_r_q == AW'(1));
                pad_left = (wr_c_q == AW'(1));
                shift_en = accept;
            end
            EDGE: begin
                // Emit the right-edge window and preload column 0 for a following flush.
                rd_addr   = '0;
                win_due   = 1'b1;
                win_row   = edge_row_q;
                win_col   = LAST;
                pad_top   = (edge_row_q == '0);
                pad_right = 1'b1;
                shift_en  = 1'b1;
            end
            FLUSH: begin
                rd_addr   = (fc_q == LAST) ? '0 : fc_q + AW'(1);
                win_due   = 1'b1;
                win_row   = LAST;
                win_col   = fc_q;
                pad_bot   = 1'b1;
                pad_left  = (fc_q == '0);
                pad_right = (fc_q == LAST);
                shift_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_col[0] = lb_top_mem[rd_addr];
        rd_col[1] = lb_mid_mem[rd_addr];
        rd_col[2] = (state_q == RUN) ? in_pixel : '0;
    end

    assign win_cols[0] = col_a_q;
    assign win_cols[1] = col_b_q;
    assign win_cols[2] = rd_col;

    always_comb begin
        wr_r_d     = wr_r_q;
        wr_c_d     = wr_c_q;
        edge_row_d = edge_row_q;
        last_row_d = last_row_q;
        if (accept) begin
            if (wr_c_q == LAST) begin
                wr_c_d     = '0;
                wr_r_d     = (wr_r_q == LAST) ? '0 : wr_r_q + AW'(1);
                edge_row_d = wr_r_q - AW'(1);
                last_row_d = (wr_r_q == LAST);
            end else begin
                wr_c_d = wr_c_q + AW'(1);
            end
        end
        fc_d = (state_q == FLUSH && fc_q != LAST) ? fc_q + AW'(1) : '0;

        col_a_d = col_a_q;
        col_b_d = col_b_q;
        if (shift_en) begin
            col_a_d = col_b_q;
            col_b_d = rd_col;
        end

        out_valid_d  = win_due && (int'(win_row) % STRIDE == 0) && (int'(win_col) % STRIDE == 0);
        out_window_d = out_window_q;
        tap_pad      = 1'b0;
        if (out_valid_d) begin
            for (int kx = 0; kx < 3; kx++) begin
                for (int ky = 0; ky < 3; ky++) begin
                    tap_pad = (ky == 0 && pad_top) || (ky == 2 && pad_bot) ||
                              (kx == 0 && pad_left) || (kx == 2 && pad_right);
                    for (int ch = 0; ch < CH; ch++) begin
                        out_window_d[(ch*9 + ky*3 + kx)*bitsize +: bitsize] =
                            tap_pad ? '0 : win_cols[kx][ky][ch*bitsize +: bitsize];
                    end
                end
            end
        end
    end

    assign out_window = out_window_q;
    assign out_valid  = out_valid_q;

`ifdef WINBUF_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = out_valid_d && win_row == LAST_EMIT && win_col == LAST_EMIT;
    end

    always_ff @(posedge clk) begin
        if (rst) frame_done_q <= 1'b0;
        else     frame_done_q <= frame_done_d;
    end

    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_fmap_window_buffer.sv
// Bench for fmap_window_buffer: IMG_SIZE=4, CH=2, one STRIDE=1 and one STRIDE=2 instance.
`timescale 1ns/1ps
module tb_fmap_window_buffer;
    localparam int B  = 18;
    localparam int CH = 2;
    localparam int N  = 4;
    localparam int PW = CH * B;
    localparam int WW = CH * 9 * B;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PW-1:0] in_pixel1, in_pixel2;
    logic          in_valid1, in_valid2, in_ready1, in_ready2, out_valid1, out_valid2;
    logic [WW-1:0] out_window1, out_window2;
    logic          fd1, fd2;

`ifdef WINBUF_FRAME_DONE_EN
    logic frame_done1, frame_done2;
    assign fd1 = frame_done1;
    assign fd2 = frame_done2;
`else
    assign fd1 = 1'b0;
    assign fd2 = 1'b0;
`endif

    fmap_window_buffer #(.bitsize(B), .CH(CH), .IMG_SIZE(N), .STRIDE(1)) u_s1 (
        .clk(clk), .rst(rst), .in_pixel(in_pixel1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_window(out_window1), .out_valid(out_valid1)
`ifdef WINBUF_FRAME_DONE_EN
        , .frame_done(frame_done1)
`endif
    );

    fmap_window_buffer #(.bitsize(B), .CH(CH), .IMG_SIZE(N), .STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .in_pixel(in_pixel2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_window(out_window2), .out_valid(out_valid2)
`ifdef WINBUF_FRAME_DONE_EN
        , .frame_done(frame_done2)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [WW-1:0] obs1_win[$], obs2_win[$], exp_q[$], ref1[$];
    int            obs1_cyc[$], acc_cyc[$];
    bit            obs1_fd[$], obs2_fd[$], rdy_log[$];
    int            stray_fd = 0;
    logic [PW-1:0] pix_mem [0:63];

    always @(negedge clk) begin
        if (out_valid1) begin
            obs1_win.push_back(out_window1);
            obs1_cyc.push_back(cyc);
            obs1_fd.push_back(fd1);
        end
        if (out_valid2) begin
            obs2_win.push_back(out_window2);
            obs2_fd.push_back(fd2);
        end
        if ((fd1 && !out_valid1) || (fd2 && !out_valid2)) stray_fd++;
    end

    function automatic logic [PW-1:0] spec_pix(input int r, input int c);
        logic [B-1:0] v;
        v = B'(4*r + c + 1);
        return {-v, v};
    endfunction

    function automatic logic [WW-1:0] lit_window(input int t [9]);
        logic [WW-1:0] w;
        logic [B-1:0]  v;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            v = B'(t[k]);
            w[k*B +: B]     = v;
            w[(9+k)*B +: B] = -v;
        end
        return w;
    endfunction

    // Reference window: each tap is the source pixel at (r+ky-1, c+kx-1), or zero off the map.
    function automatic logic [WW-1:0] exp_window(input int base, input int r, input int c);
        logic [WW-1:0] w;
        logic [PW-1:0] p;
        int rr, cc;
        w = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                rr = r + ky - 1;
                cc = c + kx - 1;
                if (rr >= 0 && rr < N && cc >= 0 && cc < N) begin
                    p = pix_mem[base + rr*N + cc];
                    for (int ch = 0; ch < CH; ch++) w[(ch*9 + ky*3 + kx)*B +: B] = p[ch*B +: B];
                end
            end
        end
        return w;
    endfunction

    task automatic build_exp(input int nframes, input int stride);
        exp_q.delete();
        for (int f = 0; f < nframes; f++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    if (r % stride == 0 && c % stride == 0) exp_q.push_back(exp_window(f*N*N, r, c));
    endtask

    task automatic load_spec_frames(input int nframes);
        for (int f = 0; f < nframes; f++)
            for (int i = 0; i < N*N; i++) pix_mem[f*N*N + i] = spec_pix(i / N, i % N);
    endtask

    // Offers beats with the given duty; a refused beat is held until accepted.
    task automatic drive(input int sel, input int nbeats, input int duty, input int tail);
        int idx, guard, extra;
        bit v, rdy;
        idx = 0; guard = 0; extra = 0;
        acc_cyc.delete();
        rdy_log.delete();
        while ((idx < nbeats || extra < tail) && guard < 5000) begin
            v = (idx < nbeats) && ($urandom_range(0, 99) < duty);
            if (sel == 2) begin
                in_valid2 = v;
                in_pixel2 = v ? pix_mem[idx] : PW'($urandom);
            end else begin
                in_valid1 = v;
                in_pixel1 = v ? pix_mem[idx] : PW'($urandom);
            end
            @(negedge clk);
            rdy = (sel == 2) ? in_ready2 : in_ready1;
            rdy_log.push_back(rdy);
            if (v && rdy) begin
                acc_cyc.push_back(cyc);
                idx++;
            end else if (idx >= nbeats) begin
                extra++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        checks++;
        if (idx != nbeats) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", idx, nbeats);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 4;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
        if (out_window1 !== '0) begin errors++; $display("FAIL reset_out_window: got %h want 0", out_window1); end
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
        if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_s2: got %b want 1", in_ready2); end
        @(posedge clk); #1;
    endtask

    task automatic test_stride1_frame;
        int t00 [9];
        int t33 [9];
        t00 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        t33 = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
        load_spec_frames(1);
        obs1_win.delete(); obs1_cyc.delete(); obs1_fd.delete();
        drive(1, 16, 100, 12);
        build_exp(1, 1);
        checks++;
        if (obs1_win.size() != 16) begin errors++; $display("FAIL s1_count: got %0d windows want 16", obs1_win.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs1_win.size()) begin errors++; $display("FAIL s1_window_missing: idx %0d", i); end
            else if (obs1_win[i] !== exp_q[i]) begin
                errors++; $display("FAIL s1_window %0d: got %h want %h", i, obs1_win[i], exp_q[i]);
            end
        end
        ref1 = obs1_win;
        checks += 2;
        if (obs1_win.size() < 16 || obs1_win[0] !== lit_window(t00)) begin
            errors++; $display("FAIL s1_lit_00: got %h want %h", obs1_win.size() > 0 ? obs1_win[0] : '0, lit_window(t00));
        end
        if (obs1_win.size() < 16 || obs1_win[15] !== lit_window(t33)) begin
            errors++; $display("FAIL s1_lit_33: got %h want %h", obs1_win.size() > 15 ? obs1_win[15] : '0, lit_window(t33));
        end
`ifdef WINBUF_FRAME_DONE_EN
        for (int i = 0; i < obs1_fd.size(); i++) begin
            checks++;
            if (obs1_fd[i] !== (i == 15)) begin errors++; $display("FAIL s1_frame_done %0d: got %b want %b", i, obs1_fd[i], i == 15); end
        end
`endif
    endtask

    task automatic test_in_ready_latency;
        int stall, p, exp_c, r, c;
        bit er;
        load_spec_frames(1);
        obs1_win.delete(); obs1_cyc.delete(); obs1_fd.delete();
        drive(1, 16, 100, 10);
        // Stall after each right-column beat from row 1 on: 1 cycle, or 1 + N at the frame end.
        stall = 0; p = 0;
        for (int i = 0; i < rdy_log.size(); i++) begin
            er = (stall == 0);
            checks++;
            if (rdy_log[i] !== er) begin errors++; $display("FAIL in_ready cycle %0d: got %b want %b", i, rdy_log[i], er); end
            if (er && p < 16) begin
                if (p % N == N-1 && p / N >= 1) stall = (p / N == N-1) ? 1 + N : 1;
                p++;
            end else if (!er) begin
                stall--;
            end
        end
        checks++;
        if (obs1_cyc.size() != 16 || acc_cyc.size() != 16) begin
            errors++; $display("FAIL latency_counts: windows %0d beats %0d want 16 16", obs1_cyc.size(), acc_cyc.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                r = i / N; c = i % N;
                if (r < N-1 && c < N-1) exp_c = acc_cyc[(r+1)*N + c + 1] + 1;
                else if (r < N-1)       exp_c = acc_cyc[(r+1)*N + N - 1] + 2;
                else                    exp_c = acc_cyc[N*N - 1] + 3 + c;
                checks++;
                if (obs1_cyc[i] != exp_c) begin
                    errors++; $display("FAIL latency window %0d: got cycle %0d want %0d", i, obs1_cyc[i], exp_c);
                end
            end
        end
    endtask

    task automatic test_stride2;
        int t22 [9];
        t22 = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        load_spec_frames(1);
        obs2_win.delete(); obs2_fd.delete();
        drive(2, 16, 100, 12);
        build_exp(1, 2);
        checks++;
        if (obs2_win.size() != 4) begin errors++; $display("FAIL s2_count: got %0d windows want 4", obs2_win.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs2_win.size()) begin errors++; $display("FAIL s2_window_missing: idx %0d", i); end
            else if (obs2_win[i] !== exp_q[i]) begin
                errors++; $display("FAIL s2_window %0d: got %h want %h", i, obs2_win[i], exp_q[i]);
            end
        end
        checks++;
        if (obs2_win.size() < 4 || obs2_win[3] !== lit_window(t22)) begin
            errors++; $display("FAIL s2_lit_22: got %h want %h", obs2_win.size() > 3 ? obs2_win[3] : '0, lit_window(t22));
        end
`ifdef WINBUF_FRAME_DONE_EN
        for (int i = 0; i < obs2_fd.size(); i++) begin
            checks++;
            if (obs2_fd[i] !== (i == 3)) begin errors++; $display("FAIL s2_frame_done %0d: got %b want %b", i, obs2_fd[i], i == 3); end
        end
`endif
    endtask

    task automatic test_back_to_back;
        load_spec_frames(2);
        obs1_win.delete(); obs1_cyc.delete(); obs1_fd.delete();
        drive(1, 32, 30, 12);
        build_exp(2, 1);
        checks++;
        if (obs1_win.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d windows want 32", obs1_win.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs1_win.size()) begin errors++; $display("FAIL b2b_window_missing: idx %0d", i); end
            else if (obs1_win[i] !== exp_q[i] || (ref1.size() == 16 && obs1_win[i] !== ref1[i % 16])) begin
                errors++; $display("FAIL b2b_window %0d: got %h want %h", i, obs1_win[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_data;
        for (int i = 0; i < 2*N*N; i++) pix_mem[i] = PW'({$urandom, $urandom});
        obs1_win.delete(); obs1_cyc.delete(); obs1_fd.delete();
        drive(1, 32, 60, 12);
        build_exp(2, 1);
        checks++;
        if (obs1_win.size() != 32) begin errors++; $display("FAIL rnd_count: got %0d windows want 32", obs1_win.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs1_win.size()) begin errors++; $display("FAIL rnd_window_missing: idx %0d", i); end
            else if (obs1_win[i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_window %0d: got %h want %h", i, obs1_win[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int t00 [9];
        t00 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        load_spec_frames(1);
        drive(1, 7, 100, 3);
        rst = 1'b1;
        obs1_win.delete(); obs1_cyc.delete(); obs1_fd.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (obs1_win.size() != 0) begin errors++; $display("FAIL rst_no_window: got %0d windows want 0", obs1_win.size()); end
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid1); end
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready1); end
        @(posedge clk); #1;
        drive(1, 16, 100, 12);
        build_exp(1, 1);
        checks += 2;
        if (obs1_win.size() != 16) begin errors++; $display("FAIL rst_count: got %0d windows want 16", obs1_win.size()); end
        if (obs1_win.size() == 0 || obs1_win[0] !== lit_window(t00)) begin
            errors++; $display("FAIL rst_first_window: got %h want %h", obs1_win.size() > 0 ? obs1_win[0] : '0, lit_window(t00));
        end
        for (int i = 0; i < exp_q.size() && i < obs1_win.size(); i++) begin
            checks++;
            if (obs1_win[i] !== exp_q[i]) begin errors++; $display("FAIL rst_window %0d: got %h want %h", i, obs1_win[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        in_pixel1 = '0;   in_pixel2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_stride1_frame();
        test_in_ready_latency();
        test_stride2();
        test_back_to_back();
        test_random_data();
        test_reset_midframe();
        checks++;
        if (stray_fd != 0) begin errors++; $display("FAIL frame_done_stray: got %0d pulses want 0", stray_fd); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
